// File: rtl/cache_bus_arbiter.sv
// Shares the single SRAM-like bridge port between the I-cache and the D-cache.
// Address phases are arbitrated: data has priority, and inst wins after STARVE_LIMIT
// data grants. The owner of every accepted transaction is queued in order, and data_ok
// is routed back to that owner. Both handshakes pass through with no added latency.
module cache_bus_arbiter #(
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // I-cache side
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // D-cache side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // bridge side
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  output logic        protocol_err
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] FULL     = CNT_W'(OUTSTANDING);
  localparam logic [SC_W-1:0]  LIMIT    = SC_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t                 state;
  logic                   owner;       // 0 = inst, 1 = data
  logic [OUTSTANDING-1:0] fifo;        // owner id per outstanding transaction
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [SC_W-1:0]        starve_cnt;

  logic winner;
  logic winner_req;
  logic not_full;
  logic accept;
  logic pop;
  logic head;
  logic stray;
  logic owner_drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Winner: the locked owner, otherwise data unless inst is starved or data is idle
  always_comb begin
    winner = 1'b1;
    if (state == LOCKED) begin
      winner = owner;
    end else if ((starve_cnt == LIMIT) || !data_req) begin
      winner = 1'b0;
    end
  end

  assign winner_req = winner ? data_req : inst_req;
  assign not_full   = (count < FULL);

  assign bus_req    = resetn & winner_req & not_full;
  assign bus_wr     = winner ? data_wr    : inst_wr;
  assign bus_size   = winner ? data_size  : inst_size;
  assign bus_addr   = winner ? data_addr  : inst_addr;
  assign bus_wdata  = winner ? data_wdata : inst_wdata;

  assign accept       = bus_req & bus_addr_ok;
  assign inst_addr_ok = accept & ~winner;
  assign data_addr_ok = accept & winner;

  assign pop          = resetn & bus_data_ok & (count != '0);
  assign head         = fifo[rd_ptr];
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign stray      = bus_data_ok & (count == '0);
  assign owner_drop = (state == LOCKED) & ~winner_req;

  // Lock FSM: hold the grant on the current winner until the bridge accepts it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= UNLOCKED;
      owner <= 1'b0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (bus_req && !bus_addr_ok) begin
            state <= LOCKED;
            owner <= winner;
          end
        end
        LOCKED: begin
          if (owner_drop || bus_addr_ok) begin
            state <= UNLOCKED;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

  // Owner FIFO: push on address accept, pop on data return, completions in order
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        fifo[wr_ptr] <= winner;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: data grants accepted while inst keeps waiting
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_req) begin
      starve_cnt <= '0;
    end else if (accept) begin
      if (!winner) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end
    end
  end

  // Sticky error: owner abandoned a locked request, or data_ok with nothing outstanding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      protocol_err <= 1'b0;
    end else if (owner_drop || stray) begin
      protocol_err <= 1'b1;
    end
  end

endmodule
